decode_ctrl: RTL and testbench
==============================

Name: decode_ctrl

Overview:
- Decode-stage controller for the NESRV 5-stage pipeline.
- Decodes the IF/ID instruction and drives immsrcD_o combinationally to the immediate extender in the same cycle.
- Registers all remaining control into the ID/EX stage with a valid/ready handshake.
- Owns the load-use interlock (bubble insertion) and branch/jump flush of the E register.

Parameters:
- XLEN, 32, instruction/datapath width (fixed at 32; only RV32I is supported).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- instr_i  in  32  IF/ID instruction
- valid_i  in  1  instr_i valid
- ready_o  out  1  D accepts instr_i this cycle
- flush_i  in  1  kill D and E contents (taken branch/jump from E)
- immsrcD_o  out  3  extender select, combinational from instr_i
- valid_o  out  1  E register valid
- ready_i  in  1  EX accepts E register
- regwriteE_o, memwriteE_o, memreadE_o, alusrcE_o, branchE_o, jumpE_o, jalrE_o  out  1 each  registered controls
- resultsrcE_o  out  2  00 ALU, 01 mem, 10 PC+4
- alucontrolE_o  out  4  alu_op_e
- funct3E_o  out  3  branch/load/store subtype
- rdE_o, rs1E_o, rs2E_o  out  5 each  register indices
- illegal_o  out  1  registered illegal-instruction flag

Behaviour:
- Reset (async, rst_i=1): every registered output is 0, including valid_o=0 and illegal_o=0. ready_o follows its combinational equation.
- immsrcD_o mapping:
  - 000 for OP-IMM (except shifts), LOAD, JALR.
  - 101 for SLLI/SRLI/SRAI.
  - 001 for STORE.
  - 010 for all BRANCH, including BLTU/BGEU (offset is always signed).
  - 011 for JAL.
  - 111 for LUI/AUIPC.
  - 100 and 110 are never generated (reserved).
  - R-type and illegal opcodes drive 000.
- Source usage:
  - uses_rs1 is set for all opcodes except LUI, AUIPC, JAL.
  - uses_rs2 is set only for OP, STORE, BRANCH.
- advance = ready_i OR NOT valid_o.
- hazard = valid_i AND valid_o AND memreadE_o AND rdE_o != 0 AND ((uses_rs1 AND rs1 == rdE_o) OR (uses_rs2 AND rs2 == rdE_o)).
- ready_o = flush_i OR (advance AND NOT hazard).
- Register update on each clock edge, in priority order:
  1. flush_i: valid_o <= 0. The D instruction is dropped but counted as consumed, since ready_o = 1.
  2. advance AND hazard: valid_o <= 0 (bubble). The D instruction is held upstream.
  3. advance: valid_o <= valid_i; the control fields load from the decode.
  4. Otherwise (stall, ready_i = 0): all E outputs hold stable.
- Latency: one cycle from accept to valid_o.
- Load-use penalty: exactly one bubble. The hazard clears once the load leaves E.
- Bubbles and invalid slots carry all-zero control (regwrite=0, memwrite=0), so downstream may ignore valid_o for side effects.
- rd = x0: regwriteE_o is still set per opcode; the hazard check excludes rd = 0.
- flush_i asserted together with hazard or with ready_i = 0: flush wins.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcodes and bad funct3/funct7 combinations are accepted normally.
  - valid_o = 1 with all side-effect controls forced to 0.
  - illegal_o = 1 for that slot.
- Undefined:
  - illegal_o is tied 0.
  - Illegal encodings decode as a NOP bubble (valid_o = 1, zero control).

Decomposition:
- Package nesrv_pkg holds:
  - immsrc_e (the 8 codes above).
  - alu_op_e (4-bit).
  - resultsrc_e.
  - RV32I opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC).
- One natural sub-module: main_dec, purely combinational, taking opcode/funct3/funct7 and producing the control bundle and uses_rs1/uses_rs2.
- decode_ctrl holds the handshake, interlock and E register.

Test Plan:
- Reset: assert rst_i mid-stream with valid_o = 1 -> valid_o = 0 and all E controls 0 immediately, without waiting for a clock edge.
- addi x1,x2,5 (0x00510093), valid_i = 1, ready_i = 1 -> immsrcD_o = 000 and ready_o = 1 the same cycle; next cycle valid_o = 1, regwriteE = 1, alusrcE = 1, rdE = 1, rs1E = 2.
- lw x5,0(x1) (0x0000A283) then add x6,x5,x7 (0x00728333) -> at add: ready_o = 0 for one cycle, valid_o = 0 bubble, add accepted on the following cycle.
- ready_i = 0 for 3 cycles with valid_o = 1 -> E outputs unchanged and ready_o = 0 throughout.
- flush_i = 1 while the load-use hazard is active and ready_i = 0 -> ready_o = 1; next cycle valid_o = 0.
- Immediate select:
  - BLTU -> 010.
  - LUI -> 111.
  - SLLI -> 101.
  - SW -> 001.
  - 0x0000007F with DECODE_ILLEGAL_TRAP_EN -> illegal_o = 1, memwriteE = 0.

Source files
------------

// File: rtl/nesrv_pkg.sv
// Shared NESRV decode types: immediate selects, ALU ops, result sources,
// RV32I opcodes and the control bundle passed from decode into the E stage.
package nesrv_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_RSV4  = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_RSV6  = 3'b110,
    IMM_U     = 3'b111
  } immsrc_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } resultsrc_e;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic       jalr;
    resultsrc_e resultsrc;
    alu_op_e    alucontrol;
  } ctrl_t;

  // All-zero control: what bubbles, invalid slots and illegal slots carry.
  localparam ctrl_t CTRL_NOP = '{
    regwrite:   1'b0,
    memwrite:   1'b0,
    memread:    1'b0,
    alusrc:     1'b0,
    branch:     1'b0,
    jump:       1'b0,
    jalr:       1'b0,
    resultsrc:  RES_ALU,
    alucontrol: ALU_ADD
  };

  // Register-register ALU op from funct3; alt selects SUB/SRA (funct7[5]).
  function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_ctrl_main_dec.sv
// Combinational RV32I main decoder: opcode/funct3/funct7 to control bundle,
// immediate select, source-register usage and an illegal-encoding flag.
module main_dec
  import nesrv_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o,
  output immsrc_e    immsrc_o,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o,
  output logic       illegal_o
);

  // Per-opcode control; anything not listed falls through as illegal.
  always_comb begin
    ctrl_o     = CTRL_NOP;
    immsrc_o   = IMM_I;
    uses_rs1_o = 1'b1;
    uses_rs2_o = 1'b0;
    illegal_o  = 1'b0;
    case (opcode_i)
      OP: begin
        uses_rs2_o        = 1'b1;
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.alucontrol = alu_from_funct(funct3_i, funct7_i[5]);
        if (!((funct7_i == 7'h00) ||
              ((funct7_i == 7'h20) && ((funct3_i == 3'b000) || (funct3_i == 3'b101)))))
          illegal_o = 1'b1;
      end
      OP_IMM: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        case (funct3_i)
          3'b001: begin
            immsrc_o          = IMM_SHAMT;
            ctrl_o.alucontrol = ALU_SLL;
            if (funct7_i != 7'h00) illegal_o = 1'b1;
          end
          3'b101: begin
            immsrc_o          = IMM_SHAMT;
            ctrl_o.alucontrol = funct7_i[5] ? ALU_SRA : ALU_SRL;
            if ((funct7_i != 7'h00) && (funct7_i != 7'h20)) illegal_o = 1'b1;
          end
          default: ctrl_o.alucontrol = alu_from_funct(funct3_i, 1'b0);
        endcase
      end
      LOAD: begin
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.memread   = 1'b1;
        ctrl_o.alusrc    = 1'b1;
        ctrl_o.resultsrc = RES_MEM;
        if ((funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111))
          illegal_o = 1'b1;
      end
      STORE: begin
        uses_rs2_o      = 1'b1;
        immsrc_o        = IMM_S;
        ctrl_o.memwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
        if (funct3_i > 3'b010) illegal_o = 1'b1;
      end
      BRANCH: begin
        uses_rs2_o        = 1'b1;
        immsrc_o          = IMM_B;
        ctrl_o.branch     = 1'b1;
        ctrl_o.alucontrol = ALU_SUB;
        if ((funct3_i == 3'b010) || (funct3_i == 3'b011)) illegal_o = 1'b1;
      end
      JAL: begin
        uses_rs1_o       = 1'b0;
        immsrc_o         = IMM_J;
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.jump      = 1'b1;
        ctrl_o.resultsrc = RES_PC4;
      end
      JALR: begin
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.jalr      = 1'b1;
        ctrl_o.alusrc    = 1'b1;
        ctrl_o.resultsrc = RES_PC4;
        if (funct3_i != 3'b000) illegal_o = 1'b1;
      end
      LUI: begin
        uses_rs1_o        = 1'b0;
        immsrc_o          = IMM_U;
        ctrl_o.regwrite   = 1'b1;
        ctrl_o.alusrc     = 1'b1;
        ctrl_o.alucontrol = ALU_PASSB;
      end
      AUIPC: begin
        uses_rs1_o      = 1'b0;
        immsrc_o        = IMM_U;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.alusrc   = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// NESRV decode-stage controller: immediate select to the extender, ID/EX
// register with valid/ready handshake, load-use bubble and flush of E.
// Optional macro DECODE_ILLEGAL_TRAP_EN: illegal encodings raise illegal_o
// for their slot; otherwise illegal_o is tied 0 and they become NOPs.
module decode_ctrl
  import nesrv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  output logic [2:0]      immsrcD_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            regwriteE_o,
  output logic            memwriteE_o,
  output logic            memreadE_o,
  output logic            alusrcE_o,
  output logic            branchE_o,
  output logic            jumpE_o,
  output logic            jalrE_o,
  output logic [1:0]      resultsrcE_o,
  output logic [3:0]      alucontrolE_o,
  output logic [2:0]      funct3E_o,
  output logic [4:0]      rdE_o,
  output logic [4:0]      rs1E_o,
  output logic [4:0]      rs2E_o,
  output logic            illegal_o
);

  ctrl_t      dec_ctrl;
  immsrc_e    dec_immsrc;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       dec_illegal;

  logic [2:0] funct3_dec;
  logic [4:0] rd_dec;
  logic [4:0] rs1_dec;
  logic [4:0] rs2_dec;

  logic       valid_q, valid_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [2:0] funct3_q, funct3_d;
  logic [4:0] rd_q, rd_d;
  logic [4:0] rs1_q, rs1_d;
  logic [4:0] rs2_q, rs2_d;

  logic       advance;
  logic       hazard;
  logic       clear_slot;
  logic       load_slot;

  assign funct3_dec = instr_i[14:12];
  assign rd_dec     = instr_i[11:7];
  assign rs1_dec    = instr_i[19:15];
  assign rs2_dec    = instr_i[24:20];

  main_dec u_main_dec (
    .opcode_i   (instr_i[6:0]),
    .funct3_i   (funct3_dec),
    .funct7_i   (instr_i[31:25]),
    .ctrl_o     (dec_ctrl),
    .immsrc_o   (dec_immsrc),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2),
    .illegal_o  (dec_illegal)
  );

  assign immsrcD_o = dec_immsrc;

  // Handshake and load-use interlock; rd = x0 never creates a dependency.
  always_comb begin
    advance    = ready_i | ~valid_q;
    hazard     = valid_i & valid_q & ctrl_q.memread & (rd_q != 5'd0) &
                 ((uses_rs1 & (rs1_dec == rd_q)) | (uses_rs2 & (rs2_dec == rd_q)));
    ready_o    = flush_i | (advance & ~hazard);
    clear_slot = flush_i | (advance & hazard);
    load_slot  = ~clear_slot & advance;
  end

  // E-register next state: flush/bubble clear, advance loads, else hold.
  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    if (clear_slot || (load_slot && !valid_i)) begin
      valid_d  = 1'b0;
      ctrl_d   = CTRL_NOP;
      funct3_d = 3'b000;
      rd_d     = 5'd0;
      rs1_d    = 5'd0;
      rs2_d    = 5'd0;
    end else if (load_slot) begin
      valid_d  = 1'b1;
      ctrl_d   = dec_illegal ? CTRL_NOP : dec_ctrl;
      funct3_d = funct3_dec;
      rd_d     = rd_dec;
      rs1_d    = rs1_dec;
      rs2_d    = rs2_dec;
    end
  end

  // ID/EX register, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      ctrl_q   <= CTRL_NOP;
      funct3_q <= 3'b000;
      rd_q     <= 5'd0;
      rs1_q    <= 5'd0;
      rs2_q    <= 5'd0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Illegal flag follows the same clear/load/hold priority as the E slot.
  always_comb begin
    illegal_d = illegal_q;
    if (clear_slot) illegal_d = 1'b0;
    else if (load_slot) illegal_d = valid_i & dec_illegal;
  end

  // Illegal flag register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

  assign valid_o       = valid_q;
  assign regwriteE_o   = ctrl_q.regwrite;
  assign memwriteE_o   = ctrl_q.memwrite;
  assign memreadE_o    = ctrl_q.memread;
  assign alusrcE_o     = ctrl_q.alusrc;
  assign branchE_o     = ctrl_q.branch;
  assign jumpE_o       = ctrl_q.jump;
  assign jalrE_o       = ctrl_q.jalr;
  assign resultsrcE_o  = ctrl_q.resultsrc;
  assign alucontrolE_o = ctrl_q.alucontrol;
  assign funct3E_o     = funct3_q;
  assign rdE_o         = rd_q;
  assign rs1E_o        = rs1_q;
  assign rs2E_o        = rs2_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: decode table, load-use bubble, stall, flush and
// asynchronous reset, with E-stage outputs matched against a queue.
`timescale 1ns/1ps
module tb_decode_ctrl;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [1:0] resultsrc;
    logic [3:0] alucontrol;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } eout_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  immsrc;
    logic [6:0]  flags;
    logic [1:0]  res;
    logic [3:0]  alu;
    logic        ill;
    string       name;
  } vec_t;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] instr_i;
  logic        valid_i;
  logic        ready_o;
  logic        flush_i;
  logic [2:0]  immsrcD_o;
  logic        valid_o;
  logic        ready_i;
  logic        regwriteE_o, memwriteE_o, memreadE_o, alusrcE_o;
  logic        branchE_o, jumpE_o, jalrE_o;
  logic [1:0]  resultsrcE_o;
  logic [3:0]  alucontrolE_o;
  logic [2:0]  funct3E_o;
  logic [4:0]  rdE_o, rs1E_o, rs2E_o;
  logic        illegal_o;

  int          tests_run;
  int          tests_failed;
  eout_t       sb_q[$];
  eout_t       cur_exp;
  vec_t        vecs[$];

  decode_ctrl #(.XLEN(32)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instr_i       (instr_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .flush_i       (flush_i),
    .immsrcD_o     (immsrcD_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .regwriteE_o   (regwriteE_o),
    .memwriteE_o   (memwriteE_o),
    .memreadE_o    (memreadE_o),
    .alusrcE_o     (alusrcE_o),
    .branchE_o     (branchE_o),
    .jumpE_o       (jumpE_o),
    .jalrE_o       (jalrE_o),
    .resultsrcE_o  (resultsrcE_o),
    .alucontrolE_o (alucontrolE_o),
    .funct3E_o     (funct3E_o),
    .rdE_o         (rdE_o),
    .rs1E_o        (rs1E_o),
    .rs2E_o        (rs2E_o),
    .illegal_o     (illegal_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic vec_t mk_vec(input logic [31:0] instr, input logic [2:0] immsrc,
                                  input logic [6:0] flags, input logic [1:0] res,
                                  input logic [3:0] alu, input logic ill, input string name);
    vec_t v;
    v.instr  = instr;
    v.immsrc = immsrc;
    v.flags  = flags;
    v.res    = res;
    v.alu    = alu;
    v.ill    = ill;
    v.name   = name;
    return v;
  endfunction

  // flags = {regwrite, memwrite, memread, alusrc, branch, jump, jalr}
  function automatic eout_t make_exp(input vec_t v);
    eout_t e;
    {e.regwrite, e.memwrite, e.memread, e.alusrc, e.branch, e.jump, e.jalr} = v.flags;
    e.resultsrc  = v.res;
    e.alucontrol = v.alu;
    e.funct3     = v.instr[14:12];
    e.rd         = v.instr[11:7];
    e.rs1        = v.instr[19:15];
    e.rs2        = v.instr[24:20];
    e.illegal    = TRAP_EN & v.ill;
    return e;
  endfunction

  function automatic eout_t snapshot();
    eout_t e;
    e = {regwriteE_o, memwriteE_o, memreadE_o, alusrcE_o, branchE_o, jumpE_o, jalrE_o,
         resultsrcE_o, alucontrolE_o, funct3E_o, rdE_o, rs1E_o, rs2E_o, illegal_o};
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic valid, input logic ready,
                               input logic flush, input eout_t exp);
    instr_i = instr;
    valid_i = valid;
    ready_i = ready;
    flush_i = flush;
    cur_exp = exp;
    #1;
  endtask

  // One clock: at the falling edge retire the E slot against the queue and
  // queue the D instruction if it is being accepted; return 1ns past the rise.
  task automatic step();
    eout_t got;
    eout_t exp;
    @(negedge clk_i);
    if (!rst_i) begin
      if (valid_o && (ready_i || flush_i)) begin
        got = snapshot();
        if (sb_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL e_out: got valid slot %h expected no slot", got);
        end else begin
          exp = sb_q.pop_front();
          if (ready_i) checkOutput("e_out", got, exp);
        end
      end
      if (valid_i && ready_o && !flush_i) sb_q.push_back(cur_exp);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    eout_t e_lw, e_add, e_addi, e_sub;
    tests_run    = 0;
    tests_failed = 0;
    rst_i   = 1'b1;
    instr_i = 32'h0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    flush_i = 1'b0;
    cur_exp = '0;

    vecs.push_back(mk_vec(32'h00510093, 3'b000, 7'b1001000, 2'b00, 4'd0,  1'b0, "addi"));
    vecs.push_back(mk_vec(32'h00728333, 3'b000, 7'b1000000, 2'b00, 4'd0,  1'b0, "add"));
    vecs.push_back(mk_vec(32'h402081B3, 3'b000, 7'b1000000, 2'b00, 4'd1,  1'b0, "sub"));
    vecs.push_back(mk_vec(32'h0020E1B3, 3'b000, 7'b1000000, 2'b00, 4'd8,  1'b0, "or"));
    vecs.push_back(mk_vec(32'h0000A283, 3'b000, 7'b1011000, 2'b01, 4'd0,  1'b0, "lw"));
    vecs.push_back(mk_vec(32'h0050A423, 3'b001, 7'b0101000, 2'b00, 4'd0,  1'b0, "sw"));
    vecs.push_back(mk_vec(32'h0020E063, 3'b010, 7'b0000100, 2'b00, 4'd1,  1'b0, "bltu"));
    vecs.push_back(mk_vec(32'h123453B7, 3'b111, 7'b1001000, 2'b00, 4'd10, 1'b0, "lui"));
    vecs.push_back(mk_vec(32'h00309093, 3'b101, 7'b1001000, 2'b00, 4'd2,  1'b0, "slli"));
    vecs.push_back(mk_vec(32'h40415113, 3'b101, 7'b1001000, 2'b00, 4'd7,  1'b0, "srai"));
    vecs.push_back(mk_vec(32'h000000EF, 3'b011, 7'b1000010, 2'b10, 4'd0,  1'b0, "jal"));
    vecs.push_back(mk_vec(32'h00008067, 3'b000, 7'b1001001, 2'b10, 4'd0,  1'b0, "jalr"));
    vecs.push_back(mk_vec(32'h00001217, 3'b111, 7'b1001000, 2'b00, 4'd0,  1'b0, "auipc"));
    vecs.push_back(mk_vec(32'h0000007F, 3'b000, 7'b0000000, 2'b00, 4'd0,  1'b1, "bad_opcode"));
    vecs.push_back(mk_vec(32'h02208133, 3'b000, 7'b0000000, 2'b00, 4'd0,  1'b1, "bad_funct7"));

    e_addi = make_exp(vecs[0]);
    e_add  = make_exp(vecs[1]);
    e_sub  = make_exp(vecs[2]);
    e_lw   = make_exp(vecs[4]);

    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_valid", 32'(valid_o), 32'd0);
    checkOutput("reset_e", snapshot(), 32'd0);
    checkOutput("reset_ready", 32'(ready_o), 32'd1);
    rst_i = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, '0);
    step();

    // Decode table, each instruction followed by an empty slot.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].instr, 1'b1, 1'b1, 1'b0, make_exp(vecs[i]));
      checkOutput({"immsrc_", vecs[i].name}, 32'(immsrcD_o), 32'(vecs[i].immsrc));
      checkOutput({"ready_", vecs[i].name}, 32'(ready_o), 32'd1);
      step();
      applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, '0);
      step();
    end

    // lw x5 then dependent add x6,x5,x7: one bubble, add accepted after it.
    applyStimulus(vecs[4].instr, 1'b1, 1'b1, 1'b0, e_lw);
    checkOutput("lu_ready_load", 32'(ready_o), 32'd1);
    step();
    applyStimulus(vecs[1].instr, 1'b1, 1'b1, 1'b0, e_add);
    checkOutput("lu_ready_hazard", 32'(ready_o), 32'd0);
    step();
    checkOutput("lu_bubble_valid", 32'(valid_o), 32'd0);
    checkOutput("lu_bubble_ctrl", snapshot(), 32'd0);
    checkOutput("lu_ready_retry", 32'(ready_o), 32'd1);
    step();
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, '0);
    checkOutput("lu_add_valid", 32'(valid_o), 32'd1);
    step();

    // Downstream stall for three cycles with an addi held in E.
    applyStimulus(vecs[0].instr, 1'b1, 1'b1, 1'b0, e_addi);
    step();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(vecs[2].instr, 1'b1, 1'b0, 1'b0, e_sub);
      checkOutput("stall_ready", 32'(ready_o), 32'd0);
      checkOutput("stall_valid", 32'(valid_o), 32'd1);
      checkOutput("stall_hold", snapshot(), e_addi);
      step();
    end
    applyStimulus(vecs[2].instr, 1'b1, 1'b1, 1'b0, e_sub);
    checkOutput("stall_release_ready", 32'(ready_o), 32'd1);
    step();
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, '0);
    step();

    // Flush while the load-use hazard is active and EX is stalled.
    applyStimulus(vecs[4].instr, 1'b1, 1'b1, 1'b0, e_lw);
    step();
    applyStimulus(vecs[1].instr, 1'b1, 1'b0, 1'b1, e_add);
    checkOutput("flush_ready", 32'(ready_o), 32'd1);
    step();
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, '0);
    checkOutput("flush_valid", 32'(valid_o), 32'd0);
    checkOutput("flush_ctrl", snapshot(), 32'd0);
    step();
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset between clock edges with a valid slot in E.
    applyStimulus(vecs[0].instr, 1'b1, 1'b1, 1'b0, e_addi);
    step();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("pre_reset_valid", 32'(valid_o), 32'd1);
    #1;
    rst_i = 1'b1;
    #1;
    checkOutput("async_reset_valid", 32'(valid_o), 32'd0);
    checkOutput("async_reset_e", snapshot(), 32'd0);
    checkOutput("async_reset_ready", 32'(ready_o), 32'd1);
    sb_q.delete();
    step();
    rst_i = 1'b0;
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, '0);
    step();
    checkOutput("post_reset_valid", 32'(valid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
